// File: rtl/cla_multicycle_adder_if.sv
// rtl/cla_multicycle_adder_if.sv - start/busy/done operand and result bundle for cla_multicycle_adder
interface cla_multicycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/cla_multicycle_adder.sv
// rtl/cla_multicycle_adder.sv - multi-cycle add/subtract, one SLICE-bit CLA slice per clock, LSB first
module cla_multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic                    clk,
  input logic                    rst,
  cla_multicycle_adder_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("cla_multicycle_adder: WIDTH must be a multiple of SLICE");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_g;
  logic [SLICE-1:0] sl_p;
  logic [SLICE-1:0] sl_s;
  logic [SLICE:0]   sl_c;
  logic [WIDTH-1:0] res_next;

  // One CLA slice fed by the registered inter-slice carry
  always_comb begin
    sl_a    = op_a[cnt*SLICE +: SLICE];
    sl_b    = op_b[cnt*SLICE +: SLICE];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c    = '0;
    sl_c[0] = carry;
    for (int i = 0; i < SLICE; i++) begin
      sl_c[i+1] = sl_g[i] | (sl_p[i] & sl_c[i]);
    end
    sl_s     = sl_p ^ sl_c[SLICE-1:0];
    res_next = res;
    res_next[cnt*SLICE +: SLICE] = sl_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // The done cycle accepts start exactly like idle, so back-to-back ops have no bubble
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          res   <= res_next;
          carry <= sl_c[SLICE];
          if (cnt == LAST) begin
            sum_r  <= res_next;
            cout_r <= sl_c[SLICE];
            ovf_r  <= sl_c[SLICE-1] ^ sl_c[SLICE];
            cnt    <= '0;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_RUN);
  assign bus.done     = (state == S_DONE);
  assign bus.sum      = sum_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_cla_multicycle_adder.sv
// tb/tb_cla_multicycle_adder.sv - self-checking bench for cla_multicycle_adder against an arithmetic model
module tb_cla_multicycle_adder;
  localparam int W  = 16;
  localparam int NS = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  cla_multicycle_adder_if #(.WIDTH(W)) bus ();

  cla_multicycle_adder #(.WIDTH(W), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] be;
    logic [W:0]   r;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
    s  = r[W-1:0];
    co = r[W];
    ov = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Drives one start pulse and waits (bounded) for done; returns cycles to done and busy cycle count
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, output int lat, output int bcnt, output logic got);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    lat = 0; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    int lat, bcnt;
    logic got;
    logic [W-1:0] es;
    logic eco, eov;
    model(a, b, cin, sub, es, eco, eov);
    run_op(a, b, cin, sub, lat, bcnt, got);
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(NS));
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(eco));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eov));
  endtask

  initial begin
    int lat, bcnt;
    logic got;
    logic seen_done;
    logic [W-1:0] ra, rb, hold;
    logic rc, rs;

    tests = 0; fails = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;

    run_op(16'h0005, 16'h000C, 1'b0, 1'b0, lat, bcnt, got);
    chk("simple_done", 32'(got), 32'd1);
    chk("simple_lat", 32'(lat), 32'd4);
    chk("simple_busycnt", 32'(bcnt), 32'd4);
    chk("simple_busy_in_done", 32'(bus.busy), 32'd0);
    chk("simple_sum", 32'(bus.sum), 32'h0011);
    chk("simple_cout", 32'(bus.cout), 32'd0);
    chk("simple_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    chk("simple_done_pulse", 32'(bus.done), 32'd0);
    hold = bus.sum;
    repeat (3) @(negedge clk);
    chk("simple_sum_hold", 32'(bus.sum), 32'(hold));

    op_check("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    chk("ripple_sum_k", 32'(bus.sum), 32'h0000);
    chk("ripple_cout_k", 32'(bus.cout), 32'd1);
    op_check("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("sovf_sum_k", 32'(bus.sum), 32'h8000);
    chk("sovf_ovf_k", 32'(bus.overflow), 32'd1);
    op_check("sub_borrow", 16'h0009, 16'h000C, 1'b1, 1'b1);
    chk("sub_borrow_sum_k", 32'(bus.sum), 32'hFFFD);
    chk("sub_borrow_cout_k", 32'(bus.cout), 32'd0);
    op_check("sub_nob", 16'h000C, 16'h0009, 1'b0, 1'b1);
    chk("sub_nob_sum_k", 32'(bus.sum), 32'h0003);
    chk("sub_nob_cout_k", 32'(bus.cout), 32'd1);

    // Handshake: mid-run start ignored, done-cycle start accepted
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 16'hAAAA; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("hs_first_done", 32'(got), 32'd1);
    chk("hs_first_sum", 32'(bus.sum), 32'h2345);
    bus.a = 16'h0001; bus.b = 16'h0001; bus.start = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      lat++;
    end
    chk("hs_second_done", 32'(got), 32'd1);
    chk("hs_second_lat", 32'(lat), 32'd4);
    chk("hs_second_sum", 32'(bus.sum), 32'h0002);

    // Reset mid-operation
    @(negedge clk);
    bus.a = 16'hF0F0; bus.b = 16'h0F0F; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_sum", 32'(bus.sum), 32'd0);
    chk("mrst_cout", 32'(bus.cout), 32'd0);
    chk("mrst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("mrst_no_done", 32'(seen_done), 32'd0);
    op_check("post_rst", 16'h0003, 16'h0004, 1'b0, 1'b0);
    chk("post_rst_sum_k", 32'(bus.sum), 32'h0007);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (n % 6 == 0) rb = ~ra;
      op_check($sformatf("rand%0d", n), ra, rb, rc, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_multicycle_adder.md
Name: cla_multicycle_adder

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit carry look-ahead adder.
- Adds or subtracts two WIDTH-bit operands by stepping one SLICE-bit CLA slice per clock, LSB slice first. The inter-slice carry is held in a register between cycles.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Sits in arithmetic datapaths where a full-width single-cycle CLA would break timing.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of SLICE; any other value is an elaboration error.
- SLICE, 4, bits processed per cycle by the internal CLA slice. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when the block is idle or in its done cycle
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- cin  input  1  carry-in, latched on accepted start; ignored when sub=1
- sub  input  1  mode, latched on accepted start: 0 = a+b+cin, 1 = a-b (a + ~b + 1)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result registers update
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB. In sub mode, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, immediate on rst=1, any state including mid-operation):
  - FSM goes to IDLE; slice counter, carry register and operand registers clear to 0.
  - busy=0, done=0, sum=0, cout=0, overflow=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 latches a, sub ? ~b : b, and carry = sub ? 1 : cin. Counter clears to 0. Go to RUN; busy=1 from E0.
  - RUN: each edge computes slice k = counter:
    - bits [k*SLICE +: SLICE] via generate/propagate CLA (Gi=ai&bi, Pi=ai^bi, c(i+1)=Gi|Pi&ci) using the registered carry.
    - Writes that slice into the internal result register and the slice carry-out into the carry register; counter increments.
    - On the last slice (k=NSLICE-1), sum/cout/overflow update together at that edge and the FSM goes to DONE.
    - The edge of the last slice is E(NSLICE); busy drops and done rises after it.
  - DONE: lasts exactly one cycle, with done=1 and busy=0.
    - start=1 in this cycle is accepted exactly as from IDLE (back-to-back, no bubble); busy=1 again from that edge.
    - Otherwise go to IDLE.
- Latency: done is high in the cycle following edge E(NSLICE), i.e. NSLICE cycles after the start edge. Throughput is one result per NSLICE+1 cycles with back-to-back start.
- start while busy=1 is ignored; the latched operands are unaffected by input changes after acceptance.
- sum, cout and overflow change only at the completing edge or on reset, and hold their values between operations.
- overflow is taken from the MSB bit of the last slice: internal carry into bit WIDTH-1 XOR cout.
- Arithmetic is modulo 2^WIDTH. Carry ripples correctly across all slice boundaries; for example, all-ones + cin=1 must propagate through every slice.
- The counter is sized clog2(NSLICE), minimum 1 bit. NSLICE=1 is legal and gives done one cycle after start.

Test Plan (WIDTH=16, SLICE=4):
- Simple add: start with a=0x0005, b=0x000C, cin=0, sub=0 -> done pulses 4 cycles after the start edge; sum=0x0011, cout=0, overflow=0; busy high for exactly those 4 cycles.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1.
- Subtract with borrow: a=0x0009, b=0x000C, sub=1, cin=1 (cin must be ignored) -> sum=0xFFFD, cout=0, overflow=0. Then a=0x000C, b=0x0009, sub=1 -> sum=0x0003, cout=1.
- Handshake: first op a=0x1234, b=0x1111. Pulse start with a=0xAAAA mid-RUN -> ignored; first result sum=0x2345. Assert start in the done cycle with a=0x0001, b=0x0001 -> accepted; second done 4 cycles later with sum=0x0002.
- Reset mid-operation: start a=0xF0F0, b=0x0F0F, then assert rst after 2 cycles -> busy, done, sum, cout and overflow go to 0 immediately, with no done pulse. After release, a new start a=0x0003, b=0x0004 -> sum=0x0007.
